// File: rtl/jz_gpio_ctrl_pkg.sv
// Shared constants for the GPIO controller:
// bus widths, default port widths and register offsets.
package jz_gpio_ctrl_pkg;

    localparam int SW_W_DEF  = 12;
    localparam int LED_W_DEF = 16;
    localparam int BUS_AW    = 4;
    localparam int BUS_DW    = 32;

    localparam logic [BUS_AW-1:0] OFS_LED   = 4'h0;
    localparam logic [BUS_AW-1:0] OFS_SW    = 4'h4;
    localparam logic [BUS_AW-1:0] OFS_STAT  = 4'h8;
    localparam logic [BUS_AW-1:0] OFS_DBLIM = 4'hC;

    localparam int STAT_PEND  = 0;
    localparam int STAT_IRQEN = 1;

endpackage

// File: rtl/jz_debounce.sv
// Two-flop switch synchroniser followed by a whole-vector
// debouncer with a programmable settle limit.
module jz_debounce #(
    parameter int W  = 12,
    parameter int CW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  sw_in,
    input  logic [CW-1:0] lim,
    input  logic          lim_wr,
    output logic [W-1:0]  stable,
    output logic          upd
);

    logic [W-1:0]  s1;
    logic [W-1:0]  s2;
    logic [CW-1:0] cnt;
    logic          diff;

    assign diff = (s2 != stable);
    // A limit rewrite restarts the count, so it also blocks an update.
    assign upd  = diff && (cnt == lim) && !lim_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            cnt    <= '0;
        end else begin
            s1 <= sw_in;
            s2 <= s1;
            if (!diff || lim_wr) begin
                cnt <= '0;
            end else if (upd) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/jz_gpio_ctrl.sv
// GPIO controller: LED register, debounced switches,
// pending/enable interrupt status and debounce limit.
module jz_gpio_ctrl
    import jz_gpio_ctrl_pkg::*;
#(
    parameter int SW_W   = SW_W_DEF,
    parameter int LED_W  = LED_W_DEF,
    parameter int DB_W   = 20,
    parameter int DB_RST = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_ce_i,
    input  logic              bus_we_i,
    input  logic [BUS_AW-1:0] bus_addr_i,
    input  logic [BUS_DW-1:0] bus_data_i,
    output logic [BUS_DW-1:0] bus_data_o,
    output logic              bus_ack_o,
    input  logic [SW_W-1:0]   switch_on,
    output logic [LED_W-1:0]  led_out,
    output logic              int_o
);

    logic [LED_W-1:0]  led_q;
    logic [DB_W-1:0]   lim_q;
    logic [SW_W-1:0]   sw_stable;
    logic              db_upd;
    logic              pend;
    logic              irq_en;
    logic              acc;
    logic              wr;
    logic              sel_led;
    logic              sel_sw;
    logic              sel_stat;
    logic              sel_lim;
    logic [BUS_DW-1:0] rd_data;
    logic              unused_bits;

    assign unused_bits = ^bus_data_i;

    assign acc      = bus_ce_i && !bus_ack_o;
    assign wr       = acc && bus_we_i;
    assign sel_led  = (bus_addr_i == OFS_LED);
    assign sel_sw   = (bus_addr_i == OFS_SW);
    assign sel_stat = (bus_addr_i == OFS_STAT);
    assign sel_lim  = (bus_addr_i == OFS_DBLIM);

    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            sel_led:  rd_data = BUS_DW'(led_q);
            sel_sw:   rd_data = BUS_DW'(sw_stable);
            sel_stat: rd_data = BUS_DW'({irq_en, pend});
            sel_lim:  rd_data = BUS_DW'(lim_q);
            default:  rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_ack_o  <= 1'b0;
            bus_data_o <= '0;
        end else begin
            bus_ack_o  <= acc;
            bus_data_o <= (acc && !bus_we_i) ? rd_data : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q  <= '0;
            irq_en <= 1'b0;
            lim_q  <= DB_W'(DB_RST);
        end else begin
            if (wr && sel_led)
                led_q <= bus_data_i[LED_W-1:0];
            if (wr && sel_stat)
                irq_en <= bus_data_i[STAT_IRQEN];
            if (wr && sel_lim)
                lim_q <= bus_data_i[DB_W-1:0];
        end
    end

    // A debounce update outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pend <= 1'b0;
        else if (db_upd)
            pend <= 1'b1;
        else if (wr && sel_stat && bus_data_i[STAT_PEND])
            pend <= 1'b0;
    end

    jz_debounce #(
        .W  (SW_W),
        .CW (DB_W)
    ) u_db (
        .clk    (clk),
        .rst    (rst),
        .sw_in  (switch_on),
        .lim    (lim_q),
        .lim_wr (wr && sel_lim),
        .stable (sw_stable),
        .upd    (db_upd)
    );

    assign led_out = led_q;
    assign int_o   = pend && irq_en;

endmodule

// File: tb/tb_jz_gpio_ctrl.sv
// Directed self-checking bench for jz_gpio_ctrl.
// Tasks start and end at a falling clock edge.
module tb_jz_gpio_ctrl;

    logic        clk;
    logic        rst;
    logic        bus_ce_i;
    logic        bus_we_i;
    logic [3:0]  bus_addr_i;
    logic [31:0] bus_data_i;
    logic [31:0] bus_data_o;
    logic        bus_ack_o;
    logic [11:0] switch_on;
    logic [15:0] led_out;
    logic        int_o;

    int n_chk;
    int n_fail;

    jz_gpio_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bus_ce_i   (bus_ce_i),
        .bus_we_i   (bus_we_i),
        .bus_addr_i (bus_addr_i),
        .bus_data_i (bus_data_i),
        .bus_data_o (bus_data_o),
        .bus_ack_o  (bus_ack_o),
        .switch_on  (switch_on),
        .led_out    (led_out),
        .int_o      (int_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic access(input logic we, input logic [3:0] a,
                          input logic [31:0] d, output logic [31:0] r);
        bus_ce_i   = 1'b1;
        bus_we_i   = we;
        bus_addr_i = a;
        bus_data_i = d;
        @(posedge clk);
        @(negedge clk);
        check("ack_hi", {31'b0, bus_ack_o}, 32'd1);
        r        = bus_data_o;
        bus_ce_i = 1'b0;
        bus_we_i = 1'b0;
        @(negedge clk);
        check("ack_lo", {31'b0, bus_ack_o}, 32'd0);
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] r;
        access(1'b1, a, d, r);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a,
                          input logic [31:0] exp);
        logic [31:0] r;
        access(1'b0, a, 32'h0, r);
        check(tag, r, exp);
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus_ce_i   = 1'b0;
        bus_we_i   = 1'b0;
        bus_addr_i = 4'h0;
        bus_data_i = 32'h0;
        switch_on  = 12'h000;
        #3 rst = 1'b0;
        step(2);
        check("rst_led", {16'b0, led_out}, 32'h0);
        check("rst_ack", {31'b0, bus_ack_o}, 32'h0);
        check("rst_dat", bus_data_o, 32'h0);
        check("rst_int", {31'b0, int_o}, 32'h0);
        rst = 1'b1;
        step(2);

        rd_chk("lim_rst", 4'hC, 32'd50000);
        rd_chk("stat_rst", 4'h8, 32'h0);
        rd_chk("sw_rst", 4'h4, 32'h0);

        wr_reg(4'h0, 32'h0000A5A5);
        check("led_a5", {16'b0, led_out}, 32'hA5A5);
        rd_chk("rd_led_a5", 4'h0, 32'h0000A5A5);
        wr_reg(4'h0, 32'hFFFF1234);
        check("led_1234", {16'b0, led_out}, 32'h1234);
        rd_chk("rd_led_hi0", 4'h0, 32'h00001234);

        wr_reg(4'hC, 32'd4);
        wr_reg(4'h8, 32'h2);
        rd_chk("rd_lim4", 4'hC, 32'd4);
        switch_on = 12'h006;
        step(6);
        check("int_e6", {31'b0, int_o}, 32'h0);
        step(1);
        check("int_e7", {31'b0, int_o}, 32'h1);
        rd_chk("sw_006", 4'h4, 32'h006);
        rd_chk("stat_3", 4'h8, 32'h3);
        wr_reg(4'h8, 32'h3);
        check("int_clr", {31'b0, int_o}, 32'h0);
        rd_chk("stat_clr", 4'h8, 32'h2);

        switch_on = 12'h000;
        step(10);
        wr_reg(4'h8, 32'h3);
        rd_chk("sw_back0", 4'h4, 32'h0);
        switch_on = 12'h001;
        step(3);
        switch_on = 12'h000;
        step(10);
        rd_chk("glitch_sw", 4'h4, 32'h0);
        rd_chk("glitch_st", 4'h8, 32'h2);
        check("glitch_int", {31'b0, int_o}, 32'h0);

        switch_on = 12'h001;
        step(5);
        switch_on = 12'h000;
        step(12);
        check("p5_int", {31'b0, int_o}, 32'h1);
        rd_chk("p5_sw", 4'h4, 32'h0);
        rd_chk("p5_st", 4'h8, 32'h3);
        wr_reg(4'h8, 32'h1);
        rd_chk("p5_clr", 4'h8, 32'h0);

        switch_on = 12'h0F0;
        step(6);
        wr_reg(4'h8, 32'h1);
        rd_chk("race_st", 4'h8, 32'h1);
        rd_chk("race_sw", 4'h4, 32'h0F0);
        check("race_int", {31'b0, int_o}, 32'h0);

        bus_ce_i   = 1'b1;
        bus_we_i   = 1'b0;
        bus_addr_i = 4'h4;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("held_ack", {31'b0, bus_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0)
                check("held_dat", bus_data_o, 32'h0F0);
        end
        bus_ce_i = 1'b0;
        step(1);
        check("held_end", {31'b0, bus_ack_o}, 32'h0);

        wr_reg(4'h8, 32'h100);
        rd_chk("bit8_st", 4'h8, 32'h1);
        rd_chk("unmap_rd", 4'h3, 32'h0);
        wr_reg(4'h6, 32'hFFFFFFFF);
        rd_chk("unmap_led", 4'h0, 32'h1234);
        rd_chk("unmap_lim", 4'hC, 32'd4);

        switch_on  = 12'h00F;
        step(2);
        bus_ce_i   = 1'b1;
        bus_we_i   = 1'b1;
        bus_addr_i = 4'h0;
        bus_data_i = 32'hBEEF;
        #1 rst = 1'b0;
        @(negedge clk);
        bus_ce_i = 1'b0;
        bus_we_i = 1'b0;
        step(2);
        check("mid_led", {16'b0, led_out}, 32'h0);
        check("mid_ack", {31'b0, bus_ack_o}, 32'h0);
        check("mid_dat", bus_data_o, 32'h0);
        check("mid_int", {31'b0, int_o}, 32'h0);
        rst = 1'b1;
        step(2);
        check("rel_ack", {31'b0, bus_ack_o}, 32'h0);
        check("rel_led", {16'b0, led_out}, 32'h0);
        rd_chk("rel_lim", 4'hC, 32'd50000);
        rd_chk("rel_ledr", 4'h0, 32'h0);
        rd_chk("rel_st", 4'h8, 32'h0);
        wr_reg(4'hC, 32'd2);
        step(8);
        rd_chk("rel_sw", 4'h4, 32'h00F);
        rd_chk("rel_pend", 4'h8, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jz_gpio_ctrl.md
JZ_GPIO_CTRL -- requirements
Module: jz_gpio_ctrl

Interface
REQ-001 SHALL have parameter SW_W, default 12: switch input width.
REQ-002 SHALL have parameter LED_W, default 16: LED output width.
REQ-003 SHALL have parameter DB_W, default 20: debounce counter and limit width.
REQ-004 SHALL have parameter DB_RST, default 50000: reset value of the debounce limit.
REQ-005 SHALL have port clk, input, 1: single system clock, all flops on rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port bus_ce_i, input, 1: access request from the SOPC data bus.
REQ-008 SHALL have port bus_we_i, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port bus_addr_i, input, 4: byte offset; only 0x0, 0x4, 0x8 and 0xC are mapped.
REQ-010 SHALL have port bus_data_i, input, 32: write data.
REQ-011 SHALL have port bus_data_o, output, 32: read data, valid only while bus_ack_o = 1.
REQ-012 SHALL have port bus_ack_o, output, 1: one-cycle access completion pulse.
REQ-013 SHALL have port switch_on, input, SW_W: asynchronous board switches.
REQ-014 SHALL have port led_out, output, LED_W: board LEDs.
REQ-015 SHALL have port int_o, output, 1: level interrupt to the core.

Function
REQ-016 SHALL accept an access on any edge where bus_ce_i = 1 and bus_ack_o = 0, then assert bus_ack_o for exactly one cycle on the following edge; a held bus_ce_i therefore completes one access every 2 cycles.
REQ-017 SHALL use this register map:
- 0x0 LED: RW, bits [LED_W-1:0] drive led_out.
- 0x4 SW: RO, debounced switch value, zero-extended.
- 0x8 STATUS: bit0 pend (write 1 to clear), bit1 irq_en (RW).
- 0xC DBLIM: RW, bits [DB_W-1:0].
REQ-018 SHALL return 0 on reads of unused bits and of unmapped offsets; writes to unmapped offsets are ignored but still acknowledged.
REQ-019 SHALL apply each write on the same edge that raises bus_ack_o; led_out is taken directly from the LED register flops.
REQ-020 SHALL synchronise switch_on through 2 flops before any other use.
REQ-021 SHALL debounce the switches as a whole vector:
- counter cleared while synced == stable;
- counter increments while synced != stable;
- on an edge where the counter == DBLIM and synced != stable: stable <= synced, counter <= 0, pend <= 1.
REQ-022 SHALL make a switch change held from edge 1 visible in SW, with pend set, at edge DBLIM+3 (edge 3 when DBLIM = 0).
REQ-023 SHALL discard any switch glitch that lasts fewer than DBLIM+1 synchronised cycles: SW unchanged, pend unchanged.
REQ-024 SHALL let a debounce set of pend win over a same-cycle W1C write.
REQ-025 SHALL restart the counter from 0 if DBLIM is written while a debounce count is in progress.
REQ-026 SHALL drive int_o = pend AND irq_en.

Reset
REQ-027 SHALL, on rst = 0, asynchronously clear: LED, led_out, sync flops, stable, counter, pend, irq_en, bus_ack_o and bus_data_o.
REQ-028 SHALL load DBLIM with DB_RST on reset.
REQ-029 SHALL abort any access in flight when reset asserts mid-access: no ack and no register write after release.
REQ-030 SHALL treat non-zero switches at reset release as a change, setting pend after the debounce time.

Structure
REQ-031 SHALL place register offsets, SW_W/LED_W defaults and the bus widths as shared constants in the common defines file.
REQ-032 SHALL implement synchroniser plus debouncer as one sub-module, jz_debounce, with outputs stable and a 1-cycle update pulse.

Verification
REQ-033 Write LED = 0x0000A5A5, then read 0x0 -> bus_ack_o high one cycle later, led_out = 0xA5A5, read data = 0x0000A5A5.
REQ-034 DBLIM = 4, switch_on 0 -> 12'h006 held -> SW = 0x006 and pend = 1 at edge 7; with irq_en = 1, int_o = 1; write STATUS = 0x3 -> pend = 0, int_o = 0.
REQ-035 DBLIM = 4, 3-cycle pulse of 12'h001 -> SW stays 0, pend stays 0.
REQ-036 Debounce update coincident with a W1C write of pend -> pend = 1.
REQ-037 Read 0x4 every cycle with bus_ce_i held -> ack alternates 1/0; write to offset 0x8 bit8 and read unmapped offset -> read returns 0, ack still given.
REQ-038 Assert rst mid-access and mid-debounce -> all outputs 0, DBLIM = 50000, no ack after release.
